// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared DMem request types and requester identifiers.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    localparam int DMEM_DATA_W = 32;
    localparam int DMEM_ADDR_W = 32;

    // A request whose write_en field is all-zero is a read.
    localparam logic [DMEM_DATA_W-1:0] DMEM_READ = '0;

    typedef logic dmem_id_t;
    localparam dmem_id_t DMEM_ID_M0 = 1'b0;
    localparam dmem_id_t DMEM_ID_M1 = 1'b1;

    typedef struct packed {
        logic [DMEM_DATA_W-1:0] write_en;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_DATA_W-1:0] data;
    } dmem_req_t;

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter_if
// Description : Requester, downstream request and response signals of the
//               two-port DMem arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              m0_request__ENA;
    logic [DATA_W-1:0] m0_request_write_en;
    logic [ADDR_W-1:0] m0_request_addr;
    logic [DATA_W-1:0] m0_request_data;
    logic              m0_request__RDY;
    logic [DATA_W-1:0] m0_response;
    logic              m0_response__RDY;
    logic              m0_response__ENA;

    logic              m1_request__ENA;
    logic [DATA_W-1:0] m1_request_write_en;
    logic [ADDR_W-1:0] m1_request_addr;
    logic [DATA_W-1:0] m1_request_data;
    logic              m1_request__RDY;
    logic [DATA_W-1:0] m1_response;
    logic              m1_response__RDY;
    logic              m1_response__ENA;

    logic              dn_request__ENA;
    logic [DATA_W-1:0] dn_request_write_en;
    logic [ADDR_W-1:0] dn_request_addr;
    logic [DATA_W-1:0] dn_request_data;
    logic              dn_request__RDY;
    logic [DATA_W-1:0] dn_response;
    logic              dn_response__RDY;
    logic              dn_response__ENA;

    // Arbiter side
    modport slave (
        input  m0_request__ENA, m0_request_write_en, m0_request_addr, m0_request_data,
        output m0_request__RDY, m0_response, m0_response__RDY,
        input  m0_response__ENA,
        input  m1_request__ENA, m1_request_write_en, m1_request_addr, m1_request_data,
        output m1_request__RDY, m1_response, m1_response__RDY,
        input  m1_response__ENA,
        output dn_request__ENA, dn_request_write_en, dn_request_addr, dn_request_data,
        input  dn_request__RDY, dn_response, dn_response__RDY,
        output dn_response__ENA
    );

    // Requesters plus downstream memory
    modport master (
        output m0_request__ENA, m0_request_write_en, m0_request_addr, m0_request_data,
        input  m0_request__RDY, m0_response, m0_response__RDY,
        output m0_response__ENA,
        output m1_request__ENA, m1_request_write_en, m1_request_addr, m1_request_data,
        input  m1_request__RDY, m1_response, m1_response__RDY,
        output m1_response__ENA,
        input  dn_request__ENA, dn_request_write_en, dn_request_addr, dn_request_data,
        output dn_request__RDY, dn_response, dn_response__RDY,
        input  dn_response__ENA
    );
endinterface
`default_nettype wire

// File: rtl/dmem_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module      : dmem_tag_fifo
// Description : Small FIFO of requester ids for reads in flight downstream.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_tag_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  wire              CLK,
    input  wire              RST,
    input  wire              push,
    input  wire              pop,
    input  wire  [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int c_IDX_W = $clog2(DEPTH);
    localparam int c_PTR_W = c_IDX_W + 1;

    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] w_count;
    logic [WIDTH-1:0]   r_mem [DEPTH];

    // Extra pointer bit distinguishes full from empty when indices match.
    assign w_count = r_wr_ptr - r_rd_ptr;
    assign empty   = (w_count == '0);
    assign full    = (w_count == c_PTR_W'(DEPTH));
    assign dout    = r_mem[r_rd_ptr[c_IDX_W-1:0]];

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (push) r_mem[r_wr_ptr[c_IDX_W-1:0]] <= din;
    end
endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Round-robin sharing of one in-order DMem port between two
//               requesters, with read ownership tracked in a tag FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DATA_W          = 32,
    parameter int ADDR_W          = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  wire           CLK,
    input  wire           RST,
    dmem_arbiter_if.slave bus,
    output logic          protocol_err
);
    typedef struct packed {
        logic [DATA_W-1:0] write_en;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

    localparam logic [DATA_W-1:0] c_READ = DATA_W'(DMEM_READ);

    req_t     r_buf [2];
    logic [1:0] r_valid;
    req_t     w_req_in [2];
    logic [1:0] w_req_ena;
    logic [1:0] w_elig;
    logic [1:0] w_issue;
    logic     w_any;
    dmem_id_t r_rr;
    dmem_id_t w_grant_id;
    dmem_id_t w_head;
    logic     w_full;
    logic     w_empty;
    logic     w_push;
    logic     w_pop;
    logic     w_rsp_rdy0;
    logic     w_rsp_rdy1;
    logic     r_protocol_err;

    assign w_req_ena   = {bus.m1_request__ENA, bus.m0_request__ENA};
    assign w_req_in[0] = {bus.m0_request_write_en, bus.m0_request_addr, bus.m0_request_data};
    assign w_req_in[1] = {bus.m1_request_write_en, bus.m1_request_addr, bus.m1_request_data};

    // Ready depends only on buffer state, never on any ENA.
    assign bus.m0_request__RDY = RST || !r_valid[0];
    assign bus.m1_request__RDY = RST || !r_valid[1];

    always_comb begin
        w_elig = '0;
        for (int i = 0; i < 2; i++) begin
            w_elig[i] = r_valid[i] && bus.dn_request__RDY &&
                        ((r_buf[i].write_en != c_READ) || !w_full);
        end
        w_any      = |w_elig;
        w_grant_id = DMEM_ID_M0;
        if (&w_elig)        w_grant_id = r_rr;
        else if (w_elig[1]) w_grant_id = DMEM_ID_M1;
        w_issue = '0;
        if (w_any && !RST) w_issue[w_grant_id] = 1'b1;
    end

    assign bus.dn_request__ENA     = |w_issue;
    assign bus.dn_request_write_en = r_buf[w_grant_id].write_en;
    assign bus.dn_request_addr     = r_buf[w_grant_id].addr;
    assign bus.dn_request_data     = r_buf[w_grant_id].data;
    assign w_push = (|w_issue) && (r_buf[w_grant_id].write_en == c_READ);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_valid <= '0;
            r_rr    <= DMEM_ID_M0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_issue[i])                        r_valid[i] <= 1'b0;
                else if (w_req_ena[i] && !r_valid[i]) r_valid[i] <= 1'b1;
            end
            if (w_any) r_rr <= ~w_grant_id;
        end
    end

    always_ff @(posedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            if (w_req_ena[i] && !r_valid[i]) r_buf[i] <= w_req_in[i];
        end
    end

    dmem_tag_fifo #(
        .WIDTH ($bits(dmem_id_t)),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_grant_id),
        .dout  (w_head),
        .empty (w_empty),
        .full  (w_full)
    );

    // The FIFO head names the owner of the next in-order response.
    assign w_rsp_rdy0 = !RST && bus.dn_response__RDY && !w_empty && (w_head == DMEM_ID_M0);
    assign w_rsp_rdy1 = !RST && bus.dn_response__RDY && !w_empty && (w_head == DMEM_ID_M1);
    assign w_pop      = (w_rsp_rdy0 && bus.m0_response__ENA) || (w_rsp_rdy1 && bus.m1_response__ENA);

    assign bus.m0_response      = bus.dn_response;
    assign bus.m1_response      = bus.dn_response;
    assign bus.m0_response__RDY = w_rsp_rdy0;
    assign bus.m1_response__RDY = w_rsp_rdy1;
    assign bus.dn_response__ENA = w_pop;

    always_ff @(posedge CLK) begin
        if (RST)                                r_protocol_err <= 1'b0;
        else if (bus.dn_response__RDY && w_empty) r_protocol_err <= 1'b1;
    end

    assign protocol_err = r_protocol_err;
endmodule
`default_nettype wire
